// File: rtl/picorv32_mem_la_tracker.sv
// picorv32_mem_la_tracker
//
// Multi-channel look-ahead request tracker for the PicoRV32 memory interface.
// Each channel converts a look-ahead read/write strobe into a registered
// mem_valid/mem_ready transaction of one or two beats. A small control register
// provides a soft reset and a sticky lock bit.
//
// Optional feature macro: PICORV32_LA_SOFTRST_LOCK_EN
//   defined   - the lock bit is sticky, and soft-reset writes made while locked
//               are rejected with a cfg_err pulse.
//   undefined - cfg_lock and cfg_err are tied low, and every soft-reset write
//               is honoured.
//
// Ports:
//   clk, reset            clock and synchronous active-high hard reset
//   mem_la_read/_write    per-channel look-ahead request strobes
//   mem_la_two_word       per-channel two-beat flag, sampled with the request
//   mem_ready             per-channel memory handshake
//   mem_valid             per-channel request outstanding
//   mem_la_firstword_reg  first beat of a two-word access outstanding
//   last_mem_valid        mem_valid delayed by one cycle
//   done                  one-cycle pulse after the final beat
//   xact_cnt              per-channel completed-transaction counters (CNT_W each)
//   cfg_we, cfg_wdata     control write (bit0 softrst, bit1 lock)
//   cfg_lock, cfg_err     lock state and rejected-write pulse
module picorv32_mem_la_tracker #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       mem_la_read,
    input  logic [NUM_CH-1:0]       mem_la_write,
    input  logic [NUM_CH-1:0]       mem_la_two_word,
    input  logic [NUM_CH-1:0]       mem_ready,
    output logic [NUM_CH-1:0]       mem_valid,
    output logic [NUM_CH-1:0]       mem_la_firstword_reg,
    output logic [NUM_CH-1:0]       last_mem_valid,
    output logic [NUM_CH-1:0]       done,
    output logic [NUM_CH*CNT_W-1:0] xact_cnt,
    input  logic                    cfg_we,
    input  logic [1:0]              cfg_wdata,
    output logic                    cfg_lock,
    output logic                    cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT1 = 2'd1,
        S_BEAT2 = 2'd2
    } state_t;

    state_t state_q [NUM_CH];
    state_t state_d [NUM_CH];

    logic [NUM_CH-1:0]            valid_q, valid_d;
    logic [NUM_CH-1:0]            firstword_q, firstword_d;
    logic [NUM_CH-1:0]            last_valid_q, last_valid_d;
    logic [NUM_CH-1:0]            done_q, done_d;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                         lock_q, lock_d;
    logic                         err_q, err_d;
    logic                         softrst;

`ifndef PICORV32_LA_SOFTRST_LOCK_EN
    // The lock bit has no function in this build.
    logic unused_lock_wdata;
    assign unused_lock_wdata = cfg_wdata[1];
`endif

    // Control register: decisions use the lock value held before this write,
    // so a single "11" write while unlocked both soft-resets and locks.
    always_comb begin
        lock_d  = lock_q;
        err_d   = 1'b0;
        softrst = 1'b0;
`ifdef PICORV32_LA_SOFTRST_LOCK_EN
        if (cfg_we) begin
            if (cfg_wdata[1]) begin
                lock_d = 1'b1;
            end
            if (cfg_wdata[0]) begin
                if (lock_q) begin
                    err_d = 1'b1;
                end else begin
                    softrst = 1'b1;
                end
            end
        end
`else
        lock_d  = 1'b0;
        softrst = cfg_we & cfg_wdata[0];
`endif
    end

    // Per-channel transaction FSMs; soft reset overrides any FSM update,
    // including a completing handshake in the same cycle.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i]      = state_q[i];
            valid_d[i]      = valid_q[i];
            firstword_d[i]  = firstword_q[i];
            last_valid_d[i] = valid_q[i];
            done_d[i]       = 1'b0;
            cnt_d[i]        = cnt_q[i];

            case (state_q[i])
                S_IDLE: begin
                    // Read and write are tracked identically; a simultaneous
                    // read+write counts as a single (write) request.
                    if (mem_la_read[i] | mem_la_write[i]) begin
                        valid_d[i]     = 1'b1;
                        firstword_d[i] = mem_la_two_word[i];
                        state_d[i]     = mem_la_two_word[i] ? S_BEAT1 : S_BEAT2;
                    end
                end
                S_BEAT1: begin
                    if (valid_q[i] & mem_ready[i]) begin
                        firstword_d[i] = 1'b0;
                        state_d[i]     = S_BEAT2;
                    end
                end
                S_BEAT2: begin
                    if (valid_q[i] & mem_ready[i]) begin
                        valid_d[i] = 1'b0;
                        done_d[i]  = 1'b1;
                        cnt_d[i]   = cnt_q[i] + CNT_W'(1);
                        state_d[i] = S_IDLE;
                    end
                end
                default: begin
                    state_d[i] = S_IDLE;
                end
            endcase

            if (softrst) begin
                state_d[i]      = S_IDLE;
                valid_d[i]      = 1'b0;
                firstword_d[i]  = 1'b0;
                last_valid_d[i] = 1'b0;
                done_d[i]       = 1'b0;
                cnt_d[i]        = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= S_IDLE;
            end
            valid_q      <= '0;
            firstword_q  <= '0;
            last_valid_q <= '0;
            done_q       <= '0;
            cnt_q        <= '0;
            lock_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
            end
            valid_q      <= valid_d;
            firstword_q  <= firstword_d;
            last_valid_q <= last_valid_d;
            done_q       <= done_d;
            cnt_q        <= cnt_d;
            lock_q       <= lock_d;
            err_q        <= err_d;
        end
    end

    assign mem_valid            = valid_q;
    assign mem_la_firstword_reg = firstword_q;
    assign last_mem_valid       = last_valid_q;
    assign done                 = done_q;
    assign xact_cnt             = cnt_q;
    assign cfg_lock             = lock_q;
    assign cfg_err              = err_q;

endmodule

// File: tb/tb_picorv32_mem_la_tracker.sv
module tb_picorv32_mem_la_tracker;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 2;

`ifdef PICORV32_LA_SOFTRST_LOCK_EN
    localparam logic LK = 1'b1;
`else
    localparam logic LK = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_CH-1:0]       mem_la_read;
    logic [NUM_CH-1:0]       mem_la_write;
    logic [NUM_CH-1:0]       mem_la_two_word;
    logic [NUM_CH-1:0]       mem_ready;
    logic [NUM_CH-1:0]       mem_valid;
    logic [NUM_CH-1:0]       mem_la_firstword_reg;
    logic [NUM_CH-1:0]       last_mem_valid;
    logic [NUM_CH-1:0]       done;
    logic [NUM_CH*CNT_W-1:0] xact_cnt;
    logic                    cfg_we;
    logic [1:0]              cfg_wdata;
    logic                    cfg_lock;
    logic                    cfg_err;

    int total = 0;
    int bad   = 0;

    picorv32_mem_la_tracker #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk                  (clk),
        .reset                (reset),
        .mem_la_read          (mem_la_read),
        .mem_la_write         (mem_la_write),
        .mem_la_two_word      (mem_la_two_word),
        .mem_ready            (mem_ready),
        .mem_valid            (mem_valid),
        .mem_la_firstword_reg (mem_la_firstword_reg),
        .last_mem_valid       (last_mem_valid),
        .done                 (done),
        .xact_cnt             (xact_cnt),
        .cfg_we               (cfg_we),
        .cfg_wdata            (cfg_wdata),
        .cfg_lock             (cfg_lock),
        .cfg_err              (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] rd, wr, tw, rdy;
        logic       we;
        logic [1:0] wd;
        logic [1:0] ev, efw, elmv, edn;
        logic [3:0] ecnt;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Inputs applied 1ns after an edge, sampled at the next edge, checked 1ns later.
    task automatic drive(input logic [1:0] rd, input logic [1:0] wr, input logic [1:0] tw,
                         input logic [1:0] rdy, input logic we, input logic [1:0] wd);
        mem_la_read     = rd;
        mem_la_write    = wr;
        mem_la_two_word = tw;
        mem_ready       = rdy;
        cfg_we          = we;
        cfg_wdata       = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [1:0] ev, input logic [1:0] efw,
                           input logic [1:0] elmv, input logic [1:0] edn, input logic [3:0] ecnt,
                           input logic elock, input logic eerr);
        chk({tag, " mem_valid"}, 32'(mem_valid), 32'(ev));
        chk({tag, " firstword"}, 32'(mem_la_firstword_reg), 32'(efw));
        chk({tag, " last_mem_valid"}, 32'(last_mem_valid), 32'(elmv));
        chk({tag, " done"}, 32'(done), 32'(edn));
        chk({tag, " xact_cnt"}, 32'(xact_cnt), 32'(ecnt));
        chk({tag, " cfg_lock"}, 32'(cfg_lock), 32'(elock));
        chk({tag, " cfg_err"}, 32'(cfg_err), 32'(eerr));
    endtask

    initial begin
        //              rd     wr     tw     rdy    we    wd     ev     efw    elmv   edn    ecnt
        // two-word read on ch1, ready on 2nd and 3rd valid cycles
        vt.push_back('{2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 4'b0000});
        vt.push_back('{2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 4'b0000});
        vt.push_back('{2'b00, 2'b00, 2'b00, 2'b10, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 4'b0000});
        vt.push_back('{2'b00, 2'b00, 2'b00, 2'b10, 1'b0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 4'b0100});
        vt.push_back('{2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0100});
        // back-to-back single-word writes on ch0 with ready held: count 1,2,3,0
        vt.push_back('{2'b00, 2'b01, 2'b00, 2'b01, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 4'b0100});
        vt.push_back('{2'b00, 2'b01, 2'b00, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 4'b0101});
        vt.push_back('{2'b00, 2'b01, 2'b00, 2'b01, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 4'b0101});
        vt.push_back('{2'b00, 2'b01, 2'b00, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 4'b0110});
        vt.push_back('{2'b01, 2'b01, 2'b00, 2'b01, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 4'b0110});
        vt.push_back('{2'b00, 2'b01, 2'b00, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 4'b0111});
        vt.push_back('{2'b00, 2'b01, 2'b00, 2'b01, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 4'b0111});
        vt.push_back('{2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 4'b0100});
        // ch1 single read; a two-word request while busy is ignored
        vt.push_back('{2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 4'b0100});
        vt.push_back('{2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 4'b0100});
        vt.push_back('{2'b00, 2'b00, 2'b00, 2'b10, 1'b0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 4'b1000});
        vt.push_back('{2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'b1000});
        // soft reset mid-transfer with ready high: aborts without done or count
        vt.push_back('{2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 4'b1000});
        vt.push_back('{2'b00, 2'b00, 2'b00, 2'b11, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000});
        vt.push_back('{2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000});

        reset = 1'b1;
        drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00);
        drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00);
        chk_all("reset", 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0);
        reset = 1'b0;

        foreach (vt[i]) begin
            drive(vt[i].rd, vt[i].wr, vt[i].tw, vt[i].rdy, vt[i].we, vt[i].wd);
            chk_all($sformatf("v%0d", i), vt[i].ev, vt[i].efw, vt[i].elmv, vt[i].edn,
                    vt[i].ecnt, 1'b0, 1'b0);
        end

        // Lock, then attempted soft reset, then attempted clear; ch0 busy throughout.
        drive(2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00);
        chk_all("b1", 2'b01, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0);
        drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b10);
        chk_all("b2 lock", 2'b01, 2'b00, 2'b01, 2'b00, 4'b0000, LK, 1'b0);
        drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b01);
        chk_all("b3 softrst", {1'b0, LK}, 2'b00, {1'b0, LK}, 2'b00, 4'b0000, LK, LK);
        drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00);
        chk_all("b4 clear", {1'b0, LK}, 2'b00, {1'b0, LK}, 2'b00, 4'b0000, LK, 1'b0);
        drive(2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 2'b00);
        chk_all("b5", 2'b00, 2'b00, {1'b0, LK}, {1'b0, LK}, {3'b000, LK}, LK, 1'b0);

        // Hard reset while ch0 is in its first beat, ready high.
        drive(2'b01, 2'b00, 2'b01, 2'b00, 1'b0, 2'b00);
        chk_all("a1", 2'b01, 2'b01, 2'b00, 2'b00, {3'b000, LK}, LK, 1'b0);
        reset = 1'b1;
        drive(2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 2'b00);
        chk_all("a2 hardrst", 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0);
        reset = 1'b0;

        // Combined 11 write while unlocked, then a 01 write.
        drive(2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00);
        chk_all("c1", 2'b10, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0);
        drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b11);
        chk_all("c2 wr11", 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, LK, 1'b0);
        drive(2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00);
        chk_all("c3", 2'b01, 2'b00, 2'b00, 2'b00, 4'b0000, LK, 1'b0);
        drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b01);
        chk_all("c4 wr01", {1'b0, LK}, 2'b00, {1'b0, LK}, 2'b00, 4'b0000, LK, LK);
        drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00);
        chk_all("c5", {1'b0, LK}, 2'b00, {1'b0, LK}, 2'b00, 4'b0000, LK, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/picorv32_mem_la_tracker.md
# picorv32_mem_la_tracker

Multi-channel memory look-ahead request tracker for the PicoRV32 memory interface. It turns per-channel look-ahead read/write strobes into registered `mem_valid`/`mem_ready` transactions, including two-word accesses. It maintains `mem_la_firstword_reg` and `last_mem_valid` per channel. It also provides a soft-reset control register whose lock bit, once set, cannot be cleared or bypassed until a hard reset.

## Interface

Parameters:
- `NUM_CH`, 2: number of independent request channels, 1..8.
- `CNT_W`, 8: width of the per-channel completed-transaction counter.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high hard reset.
- `mem_la_read` in NUM_CH: per-channel look-ahead read request.
- `mem_la_write` in NUM_CH: per-channel look-ahead write request.
- `mem_la_two_word` in NUM_CH: the request needs two beats; sampled with the request.
- `mem_ready` in NUM_CH: per-channel memory handshake.
- `mem_valid` out NUM_CH: per-channel request outstanding.
- `mem_la_firstword_reg` out NUM_CH: high while the first beat of a two-word access is outstanding.
- `last_mem_valid` out NUM_CH: `mem_valid` delayed by one cycle.
- `done` out NUM_CH: one-cycle pulse after the final beat handshake.
- `xact_cnt` out NUM_CH*CNT_W: completed transactions per channel; channel i occupies bits [i*CNT_W +: CNT_W].
- `cfg_we` in 1: control register write strobe.
- `cfg_wdata` in 2: bit0 = softrst request, bit1 = lock.
- `cfg_lock` out 1: current lock state.
- `cfg_err` out 1: one-cycle pulse when a write is rejected.

## Operation

- Per-channel FSM states: IDLE, BEAT1, BEAT2.
- IDLE:
  - Request = `mem_la_read | mem_la_write`. If both are high, treat as a write.
  - On a request, go to BEAT1 if `mem_la_two_word` = 1, otherwise go to BEAT2.
  - Set `mem_valid` = 1. Set `mem_la_firstword_reg` = `mem_la_two_word`.
- BEAT1: on `mem_valid & mem_ready`, clear `mem_la_firstword_reg` and go to BEAT2. `mem_valid` stays high.
- BEAT2: on `mem_valid & mem_ready`, clear `mem_valid`, go to IDLE, pulse `done`, and increment `xact_cnt` (wraps modulo 2^CNT_W).
- Requests arriving while a channel is not IDLE are ignored; no queuing.
- `last_mem_valid[i]` <= `mem_valid[i]` every cycle.
- Control register writes:
  - A write with bit1 = 1 sets `cfg_lock`.
  - A write with bit1 = 0 never clears `cfg_lock`. Only `reset` clears it.
  - A write with bit0 = 1 while unlocked performs a soft reset.
  - A write with bit0 = 1 while locked is ignored and pulses `cfg_err` on the next cycle.
  - A lock/softrst decision uses the lock value held before the write.
  - A single write with bits = 11 while unlocked performs the soft reset and sets the lock.
- Soft reset effect on all channels:
  - FSMs go to IDLE.
  - `mem_valid`, `mem_la_firstword_reg`, `last_mem_valid`, `done`, and `xact_cnt` are cleared.
  - `cfg_lock` is unaffected.
- Priority: `reset` > soft reset > FSM update. A soft reset aborts in-flight transactions without a `done` pulse or count increment, even if `mem_ready` is high in that cycle.
- Reset values: all outputs 0, all FSMs IDLE, `cfg_lock` = 0.

## Timing

- Request sampled in IDLE at edge t; `mem_valid` is high from t+1.
- Single-word access: handshake at edge t+k; `mem_valid` is low and `done` is high from t+k+1.
- Two-word access: `mem_la_firstword_reg` is high from t+1 through the first handshake edge. The second beat follows with no idle cycle.
- Minimum channel turnaround: the channel is IDLE in the `done` cycle and accepts a new request at that edge. Back-to-back single-word transfers with `mem_ready` held high therefore give `mem_valid` high 1 cycle out of every 2.
- A soft reset written at edge t takes effect at t+1.
- `cfg_err` is high at t+1 only, for a rejected write at t.
- `cfg_lock` is visible at t+1.
- Channels are fully independent; there is no cross-channel arbitration.

## Configuration

- Macro: `PICORV32_LA_SOFTRST_LOCK_EN`.
- Defined: lock behaviour exactly as above.
- Undefined:
  - `cfg_lock` is tied 0 and `cfg_wdata` bit1 is ignored.
  - Every softrst write is honoured.
  - `cfg_err` is tied 0.

## Test plan

- Hard reset mid-transfer: channel 0 in BEAT1, assert `reset` for 1 cycle -> next cycle all outputs 0, `cfg_lock` = 0.
- Two-word read on channel 1 with `mem_ready` high on the 2nd and 3rd valid cycles:
  - `mem_la_firstword_reg[1]` high for 2 cycles.
  - `mem_valid[1]` high for 3 cycles.
  - `done[1]` pulses once.
  - `xact_cnt` for channel 1 = 1.
- Counter wrap: CNT_W = 2, 4 single-word transfers -> `xact_cnt` reads 1, 2, 3, 0.
- Soft reset unlocked mid-transfer: write 01 with `mem_ready` high the same cycle -> next cycle `mem_valid` = 0, no `done` pulse, counts 0.
- Lock then clear attempt (macro defined): write 10, then write 01, then write 00 ->
  - `cfg_lock` = 1 throughout.
  - `cfg_err` pulses once, after the 01 write.
  - Channel state is untouched.
  - Only `reset` clears `cfg_lock`.
- Combined write 11 while unlocked:
  - Soft reset occurs and `cfg_lock` = 1.
  - A following 01 write is rejected with `cfg_err`.
  - With the macro undefined, the 01 write is honoured and `cfg_err` stays 0.
